atari_bus_sched: RTL and testbench

Bus scheduler between the 6502 core and the Atari 2600 peripherals (TIA, PIA/RIOT I/O and timer, RIOT RAM, cartridge ROM). Divides the system clock into CPU bus cycles and decodes each CPU address to exactly one target strobe. Captures the target's registered read data and returns it to the CPU. Implements the WSYNC halt: the CPU is held until the TIA reports the next horizontal sync.

---
 rtl/atari_bus_pkg.sv | 26 ++
 rtl/atari_addr_decode.sv | 21 ++
 rtl/atari_bus_sched.sv | 120 ++++++++++++
 tb/tb_atari_bus_sched.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/atari_bus_pkg.sv
// Shared types and constants for the Atari 2600 bus scheduler.
package atari_bus_pkg;

  typedef enum logic [1:0] {
    TGT_TIA,
    TGT_PIA,
    TGT_RAM,
    TGT_ROM
  } tgt_e;

  typedef enum logic {
    ST_RUN,
    ST_HALT
  } halt_st_e;

  localparam logic [5:0]  WSYNC_ADR = 6'h02;
  localparam int unsigned A12_BIT   = 12;
  localparam int unsigned A9_BIT    = 9;
  localparam int unsigned A7_BIT    = 7;

  // Only the low bits are compared; the caller qualifies with the TIA strobe.
  function automatic logic is_wsync(input logic [12:0] adr);
    return adr[5:0] == WSYNC_ADR;
  endfunction

endpackage

// File: rtl/atari_addr_decode.sv
// Maps a 13-bit CPU address to exactly one Atari 2600 bus target.
module atari_addr_decode
  import atari_bus_pkg::*;
(
  input  logic [12:0] adr_i,
  output tgt_e        tgt_o
);

  // The 2600 decodes partially; the remaining bits are mirrors.
  logic unused_adr;
  assign unused_adr = ^{adr_i[11:10], adr_i[8], adr_i[6:0]};

  always_comb begin
    tgt_o = TGT_TIA;
    if (adr_i[A12_BIT])     tgt_o = TGT_ROM;
    else if (!adr_i[A7_BIT]) tgt_o = TGT_TIA;
    else if (!adr_i[A9_BIT]) tgt_o = TGT_RAM;
    else                     tgt_o = TGT_PIA;
  end

endmodule

// File: rtl/atari_bus_sched.sv
// Bus scheduler between the 6502 core and the 2600 peripherals: DIV-cycle
// accesses, one registered target strobe each, and the WSYNC halt.
module atari_bus_sched
  import atari_bus_pkg::*;
#(
  parameter int unsigned DIV = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [12:0] cpu_adr_i,
  input  logic        cpu_we_i,
  input  logic [7:0]  cpu_dat_i,
  output logic [7:0]  cpu_dat_o,
  output logic        cpu_en_o,
  output logic        cpu_rdy_o,
  output logic [12:0] adr_o,
  output logic        we_o,
  output logic [7:0]  dat_o,
  output logic        tia_stb_o,
  output logic        pia_stb_o,
  output logic        ram_stb_o,
  output logic        rom_stb_o,
  input  logic [7:0]  tia_dat_i,
  input  logic [7:0]  pia_dat_i,
  input  logic [7:0]  ram_dat_i,
  input  logic [7:0]  rom_dat_i,
  input  logic        hsync_i
);

  // state   | meaning
  // ST_RUN  | accesses issue every DIV cycles
  // ST_HALT | WSYNC written; hold at phase 0 until hsync_i

  localparam logic [3:0] PH_LAST = 4'(DIV - 1);
  localparam logic [3:0] PH_CAPT = 4'd2;

  // ph_q is the phase the next cycle presents, so every output is a flop.
  logic [3:0] ph_q, ph_d;
  halt_st_e   st_q, st_d;
  logic [3:0] stb_q, stb_d;
  tgt_e       sel_q, sel_d;
  logic       en_q, en_d;
  logic [7:0] rdat_q, rdat_d;
  tgt_e       dec_tgt;
  logic       advance;
  logic [7:0] rd_mux;

  atari_addr_decode u_dec (
    .adr_i (cpu_adr_i),
    .tgt_o (dec_tgt)
  );

  assign advance = (st_q == ST_RUN) || (ph_q != 4'd0) || hsync_i;

  always_comb begin
    rd_mux = tia_dat_i;
    case (sel_q)
      TGT_TIA: rd_mux = tia_dat_i;
      TGT_PIA: rd_mux = pia_dat_i;
      TGT_RAM: rd_mux = ram_dat_i;
      TGT_ROM: rd_mux = rom_dat_i;
      default: rd_mux = tia_dat_i;
    endcase
  end

  always_comb begin
    ph_d   = ph_q;
    st_d   = st_q;
    stb_d  = '0;
    sel_d  = sel_q;
    en_d   = 1'b0;
    rdat_d = rdat_q;

    case (st_q)
      ST_RUN:  if (stb_q[TGT_TIA] && cpu_we_i && is_wsync(cpu_adr_i)) st_d = ST_HALT;
      ST_HALT: if (hsync_i) st_d = ST_RUN;
      default: st_d = ST_RUN;
    endcase

    if (advance) begin
      ph_d = (ph_q == PH_LAST) ? 4'd0 : ph_q + 4'd1;
      if (ph_q == 4'd0) begin
        stb_d[dec_tgt] = 1'b1;
        sel_d          = dec_tgt;
      end
      if (ph_q == PH_CAPT && !cpu_we_i) rdat_d = rd_mux;
      if (ph_q == PH_LAST) en_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ph_q   <= 4'd0;
      st_q   <= ST_RUN;
      stb_q  <= '0;
      sel_q  <= TGT_TIA;
      en_q   <= 1'b0;
      rdat_q <= 8'h00;
    end else begin
      ph_q   <= ph_d;
      st_q   <= st_d;
      stb_q  <= stb_d;
      sel_q  <= sel_d;
      en_q   <= en_d;
      rdat_q <= rdat_d;
    end
  end

  assign adr_o     = cpu_adr_i;
  assign we_o      = cpu_we_i;
  assign dat_o     = cpu_dat_i;
  assign cpu_dat_o = rdat_q;
  assign cpu_en_o  = en_q;
  assign cpu_rdy_o = (st_q == ST_RUN);
  assign tia_stb_o = stb_q[TGT_TIA];
  assign pia_stb_o = stb_q[TGT_PIA];
  assign ram_stb_o = stb_q[TGT_RAM];
  assign rom_stb_o = stb_q[TGT_ROM];

endmodule

// File: tb/tb_atari_bus_sched.sv
// Directed bench for atari_bus_sched at DIV=3 and DIV=5.
module tb_atari_bus_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] adr;
  logic        we;
  logic [7:0]  wdat;
  logic        hsync;
  logic [7:0]  tia_d, pia_d, ram_d, rom_d;

  logic [7:0]  dat3, dat5, wd3, wd5;
  logic        en3, en5, rdy3, rdy5, we3, we5;
  logic [12:0] adr3, adr5;
  logic        tia3, pia3, ram3, rom3, tia5, pia5, ram5, rom5;
  logic [3:0]  stb3, stb5;

  int n_chk = 0;
  int n_fail = 0;

  assign stb3 = {tia3, pia3, ram3, rom3};
  assign stb5 = {tia5, pia5, ram5, rom5};

  always #5 clk = ~clk;

  atari_bus_sched #(.DIV(3)) u3 (
    .clk_i(clk), .rst_ni(rst_n), .cpu_adr_i(adr), .cpu_we_i(we), .cpu_dat_i(wdat),
    .cpu_dat_o(dat3), .cpu_en_o(en3), .cpu_rdy_o(rdy3), .adr_o(adr3), .we_o(we3),
    .dat_o(wd3), .tia_stb_o(tia3), .pia_stb_o(pia3), .ram_stb_o(ram3), .rom_stb_o(rom3),
    .tia_dat_i(tia_d), .pia_dat_i(pia_d), .ram_dat_i(ram_d), .rom_dat_i(rom_d),
    .hsync_i(hsync)
  );

  atari_bus_sched #(.DIV(5)) u5 (
    .clk_i(clk), .rst_ni(rst_n), .cpu_adr_i(adr), .cpu_we_i(we), .cpu_dat_i(wdat),
    .cpu_dat_o(dat5), .cpu_en_o(en5), .cpu_rdy_o(rdy5), .adr_o(adr5), .we_o(we5),
    .dat_o(wd5), .tia_stb_o(tia5), .pia_stb_o(pia5), .ram_stb_o(ram5), .rom_stb_o(rom5),
    .tia_dat_i(tia_d), .pia_dat_i(pia_d), .ram_dat_i(ram_d), .rom_dat_i(rom_d),
    .hsync_i(hsync)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; adr = 13'h0280; we = 1'b0; wdat = 8'h00; hsync = 1'b0;
    repeat (2) tick();
    n_chk++; if (stb3 !== 4'b0000) begin n_fail++; $display("FAIL reset_stb: got %b want 0000", stb3); end
    n_chk++; if (en3 !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b want 0", en3); end
    n_chk++; if (rdy3 !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b want 1", rdy3); end
    n_chk++; if (dat3 !== 8'h00) begin n_fail++; $display("FAIL reset_dat: got %h want 00", dat3); end
    rst_n = 1'b1;
    tick();
    n_chk++; if (stb3 !== 4'b0100) begin n_fail++; $display("FAIL first_stb: got %b want 0100", stb3); end
    n_chk++; if (en3 !== 1'b0) begin n_fail++; $display("FAIL first_en0: got %b want 0", en3); end
    tick();
    n_chk++; if (stb3 !== 4'b0000) begin n_fail++; $display("FAIL first_stb1: got %b want 0000", stb3); end
    tick();
    n_chk++; if (dat3 !== 8'hA5) begin n_fail++; $display("FAIL first_dat: got %h want a5", dat3); end
    n_chk++; if (en3 !== 1'b1) begin n_fail++; $display("FAIL first_en: got %b want 1", en3); end
  endtask

  task automatic test_decode();
    logic [12:0] d_adr [5];
    logic [3:0]  d_stb [5];
    logic [7:0]  d_dat [5];
    d_adr = '{13'h1000, 13'h1FFF, 13'h0080, 13'h0009, 13'h0294};
    d_stb = '{4'b0001, 4'b0001, 4'b0010, 4'b1000, 4'b0100};
    d_dat = '{8'h77, 8'h77, 8'h3C, 8'h11, 8'hA5};
    for (int i = 0; i < 5; i++) begin
      adr = d_adr[i];
      tick();
      n_chk++; if (stb3 !== d_stb[i]) begin n_fail++; $display("FAIL decode_stb[%0d]: got %b want %b", i, stb3, d_stb[i]); end
      n_chk++; if (adr3 !== d_adr[i]) begin n_fail++; $display("FAIL decode_adr[%0d]: got %h want %h", i, adr3, d_adr[i]); end
      tick();
      tick();
      n_chk++; if (dat3 !== d_dat[i]) begin n_fail++; $display("FAIL decode_dat[%0d]: got %h want %h", i, dat3, d_dat[i]); end
      n_chk++; if (en3 !== 1'b1) begin n_fail++; $display("FAIL decode_en[%0d]: got %b want 1", i, en3); end
    end
    n_chk++; if (adr3[6:0] !== 7'h14) begin n_fail++; $display("FAIL pia_reg: got %h want 14", adr3[6:0]); end
  endtask

  task automatic test_write_hold();
    adr = 13'h0080; we = 1'b1; wdat = 8'h5A;
    tick();
    n_chk++; if (stb3 !== 4'b0010) begin n_fail++; $display("FAIL wr_stb: got %b want 0010", stb3); end
    n_chk++; if (we3 !== 1'b1) begin n_fail++; $display("FAIL wr_we: got %b want 1", we3); end
    n_chk++; if (wd3 !== 8'h5A) begin n_fail++; $display("FAIL wr_dat_o: got %h want 5a", wd3); end
    tick();
    tick();
    n_chk++; if (dat3 !== 8'hA5) begin n_fail++; $display("FAIL wr_hold: got %h want a5", dat3); end
    n_chk++; if (en3 !== 1'b1) begin n_fail++; $display("FAIL wr_en: got %b want 1", en3); end
  endtask

  task automatic test_hsync_idle();
    adr = 13'h1000; we = 1'b0;
    tick();
    hsync = 1'b1;
    tick();
    hsync = 1'b0;
    n_chk++; if (rdy3 !== 1'b1) begin n_fail++; $display("FAIL idle_rdy: got %b want 1", rdy3); end
    tick();
    n_chk++; if (en3 !== 1'b1) begin n_fail++; $display("FAIL idle_en: got %b want 1", en3); end
    tick();
    n_chk++; if (stb3 !== 4'b0001) begin n_fail++; $display("FAIL idle_period: got %b want 0001", stb3); end
    tick();
    tick();
  endtask

  task automatic test_wsync();
    int bad;
    adr = 13'h0002; we = 1'b1;
    tick();
    n_chk++; if (stb3 !== 4'b1000) begin n_fail++; $display("FAIL ws_stb: got %b want 1000", stb3); end
    tick();
    n_chk++; if (rdy3 !== 1'b0) begin n_fail++; $display("FAIL ws_rdy: got %b want 0", rdy3); end
    tick();
    n_chk++; if (en3 !== 1'b1) begin n_fail++; $display("FAIL ws_en: got %b want 1", en3); end
    adr = 13'h0080; we = 1'b0;
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (stb3 !== 4'b0000 || en3 !== 1'b0 || rdy3 !== 1'b0) bad++;
    end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL ws_hold: got %0d bad cycles want 0", bad); end
    hsync = 1'b1;
    tick();
    hsync = 1'b0;
    n_chk++; if (stb3 !== 4'b0010) begin n_fail++; $display("FAIL ws_release_stb: got %b want 0010", stb3); end
    n_chk++; if (rdy3 !== 1'b1) begin n_fail++; $display("FAIL ws_release_rdy: got %b want 1", rdy3); end
    tick();
    tick();
    n_chk++; if (dat3 !== 8'h3C) begin n_fail++; $display("FAIL ws_after_dat: got %h want 3c", dat3); end
  endtask

  task automatic test_hsync_coincident();
    adr = 13'h0002; we = 1'b1;
    tick();
    n_chk++; if (stb3 !== 4'b1000) begin n_fail++; $display("FAIL co_stb: got %b want 1000", stb3); end
    hsync = 1'b1;
    tick();
    hsync = 1'b0;
    n_chk++; if (rdy3 !== 1'b0) begin n_fail++; $display("FAIL co_rdy: got %b want 0", rdy3); end
    tick();
    repeat (10) tick();
    n_chk++; if (rdy3 !== 1'b0 || stb3 !== 4'b0000) begin n_fail++; $display("FAIL co_still_halted: got rdy %b stb %b want 0 0000", rdy3, stb3); end
    hsync = 1'b1;
    tick();
    hsync = 1'b0;
    n_chk++; if (stb3 !== 4'b1000 || rdy3 !== 1'b1) begin n_fail++; $display("FAIL co_release: got stb %b rdy %b want 1000 1", stb3, rdy3); end
    tick();
    tick();
  endtask

  task automatic test_reset_halt();
    repeat (3) tick();
    n_chk++; if (rdy3 !== 1'b0) begin n_fail++; $display("FAIL rh_pre: got %b want 0", rdy3); end
    rst_n = 1'b0;
    #1;
    n_chk++; if (rdy3 !== 1'b1) begin n_fail++; $display("FAIL rh_rdy: got %b want 1", rdy3); end
    n_chk++; if (dat3 !== 8'h00) begin n_fail++; $display("FAIL rh_dat: got %h want 00", dat3); end
    adr = 13'h1000; we = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    n_chk++; if (stb3 !== 4'b0001) begin n_fail++; $display("FAIL rh_stb: got %b want 0001", stb3); end
    tick();
    tick();
    n_chk++; if (dat3 !== 8'h77) begin n_fail++; $display("FAIL rh_dat2: got %h want 77", dat3); end
  endtask

  task automatic test_div5();
    logic [3:0] exp_stb;
    logic       exp_en;
    rst_n = 1'b0; adr = 13'h0080; we = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tick();
      exp_stb = (c % 5 == 0) ? 4'b0010 : 4'b0000;
      exp_en  = (c % 5 == 4);
      n_chk++; if (stb5 !== exp_stb) begin n_fail++; $display("FAIL d5_stb[%0d]: got %b want %b", c, stb5, exp_stb); end
      n_chk++; if (en5 !== exp_en) begin n_fail++; $display("FAIL d5_en[%0d]: got %b want %b", c, en5, exp_en); end
      if (c >= 2) begin
        n_chk++; if (dat5 !== 8'h3C) begin n_fail++; $display("FAIL d5_dat[%0d]: got %h want 3c", c, dat5); end
      end
    end
  endtask

  initial begin
    tia_d = 8'h11; pia_d = 8'hA5; ram_d = 8'h3C; rom_d = 8'h77;
    test_reset();
    test_decode();
    test_write_hold();
    test_hsync_idle();
    test_wsync();
    test_hsync_coincident();
    test_reset_halt();
    test_div5();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
